// File: rtl/ir_store_server.sv
// ----------------------------------------------------------------------------
// ir_store_server
//
// Instruction store that sits at the far end of the decoder's fetch interface.
//
// During init, the program loader streams bytes in. They are written in order
// into a 2**IR_ADDR_WIDTH entry store. When the last byte (or the LOAD_LINES-th
// byte) has been accepted, the block raises init_load_finished.
//
// After that, each accepted fetch request returns four consecutive bytes
// (IR, P0, P1, P2), starting at irp. Addresses wrap modulo the store depth.
// A word that was never written reads as 0, which is the IDLE opcode.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   i_ld_valid/i_ld_data   loader byte stream
//   i_ld_last              marks the final loader byte
//   o_ld_ready             store accepts a loader byte this cycle
//   o_init_load_finished   load phase complete (sticky until reset)
//   i_fetch_req, i_irp     fetch request and start address
//   o_fetch_busy           a new fetch request is not accepted this cycle
//   o_data_out             fetched byte (qualify with o_data_valid)
//   o_data_valid           o_data_out holds a valid beat
//   o_data_idx             beat index 0=IR, 1=P0, 2=P1, 3=P2
//   o_fetch_done           one-cycle pulse on beat 3
// ----------------------------------------------------------------------------
module ir_store_server #(
    parameter int DATA_WIDTH    = 8,
    parameter int IR_ADDR_WIDTH = 8,
    parameter int LOAD_LINES    = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_ld_valid,
    input  logic [DATA_WIDTH-1:0]    i_ld_data,
    input  logic                     i_ld_last,
    output logic                     o_ld_ready,
    output logic                     o_init_load_finished,
    input  logic                     i_fetch_req,
    input  logic [IR_ADDR_WIDTH-1:0] i_irp,
    output logic                     o_fetch_busy,
    output logic [DATA_WIDTH-1:0]    o_data_out,
    output logic                     o_data_valid,
    output logic [1:0]               o_data_idx,
    output logic                     o_fetch_done
);

    localparam int DEPTH = 1 << IR_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_BURST
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_beat;
    logic [IR_ADDR_WIDTH-1:0] r_wptr;
    logic [IR_ADDR_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0]         r_valid;

    logic                     w_load_accept;
    logic                     w_load_final;
    logic                     w_fetch_accept;
    logic [1:0]               w_next_beat;
    logic [IR_ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0]    w_rd_word;

    // A new fetch can start from READY, or from the final beat of a burst.
    // The final-beat case is what makes back-to-back bursts gapless.
    always_comb begin
        w_load_accept  = (r_state == S_LOAD) && i_ld_valid && o_ld_ready;
        w_load_final   = w_load_accept &&
                         (i_ld_last || (r_wptr == IR_ADDR_WIDTH'(LOAD_LINES - 1)));
        w_fetch_accept = i_fetch_req &&
                         ((r_state == S_READY) ||
                          ((r_state == S_BURST) && (r_beat == 2'd3)));
        w_next_beat    = r_beat + 2'd1;
    end

    // The read address is looked up one cycle ahead of the beat it feeds.
    // That is irp on an accept, and otherwise base + the next beat index.
    // The address add wraps naturally at the store depth.
    always_comb begin
        w_rd_addr = r_base + IR_ADDR_WIDTH'(w_next_beat);
        if (w_fetch_accept) begin
            w_rd_addr = i_irp;
        end
        w_rd_word = r_valid[w_rd_addr] ? r_mem[w_rd_addr] : '0;
    end

    // The storage array itself has no reset. Stale contents are masked by the
    // per-word valid bits, which are cleared on reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_load_accept) begin
            r_mem[r_wptr] <= i_ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= S_LOAD;
            r_wptr               <= '0;
            r_base               <= '0;
            r_beat               <= 2'd0;
            r_valid              <= '0;
            o_ld_ready           <= 1'b1;
            o_init_load_finished <= 1'b0;
            o_fetch_busy         <= 1'b1;
            o_data_out           <= '0;
            o_data_valid         <= 1'b0;
            o_data_idx           <= 2'd0;
            o_fetch_done         <= 1'b0;
        end else if (w_fetch_accept) begin
            // Beat 0 is registered on the accept edge.
            r_state      <= S_BURST;
            r_base       <= i_irp;
            r_beat       <= 2'd0;
            o_data_out   <= w_rd_word;
            o_data_valid <= 1'b1;
            o_data_idx   <= 2'd0;
            o_fetch_busy <= 1'b1;
            o_fetch_done <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_accept) begin
                        r_valid[r_wptr] <= 1'b1;
                        r_wptr          <= r_wptr + IR_ADDR_WIDTH'(1);
                        if (w_load_final) begin
                            r_state              <= S_READY;
                            o_ld_ready           <= 1'b0;
                            o_init_load_finished <= 1'b1;
                            o_fetch_busy         <= 1'b0;
                        end
                    end
                end
                S_READY: begin
                    o_fetch_busy <= 1'b0;
                end
                S_BURST: begin
                    if (r_beat != 2'd3) begin
                        // Busy drops on beat 3, so a request can be accepted
                        // on the final beat.
                        r_beat       <= w_next_beat;
                        o_data_out   <= w_rd_word;
                        o_data_idx   <= w_next_beat;
                        o_fetch_busy <= (w_next_beat != 2'd3);
                        o_fetch_done <= (w_next_beat == 2'd3);
                    end else begin
                        r_state      <= S_READY;
                        o_data_valid <= 1'b0;
                        o_fetch_done <= 1'b0;
                        o_fetch_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_store_server.sv
// ----------------------------------------------------------------------------
// tb_ir_store_server
//
// Directed, table-driven bench for ir_store_server.
//
// Inputs are driven just after a falling edge, and registered outputs are
// sampled on the following falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ir_store_server;

    logic       clk;
    logic       rst_n;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       init_load_finished;
    logic       fetch_req;
    logic [7:0] irp;
    logic       fetch_busy;
    logic [7:0] data_out;
    logic       data_valid;
    logic [1:0] data_idx;
    logic       fetch_done;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]      irp;
        logic [3:0][7:0] beats;
    } fetch_vec_t;

    fetch_vec_t vecA [0:4];
    fetch_vec_t vecB [0:2];

    ir_store_server #(
        .DATA_WIDTH   (8),
        .IR_ADDR_WIDTH(8),
        .LOAD_LINES   (256)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_ld_valid          (ld_valid),
        .i_ld_data           (ld_data),
        .i_ld_last           (ld_last),
        .o_ld_ready          (ld_ready),
        .o_init_load_finished(init_load_finished),
        .i_fetch_req         (fetch_req),
        .i_irp               (irp),
        .o_fetch_busy        (fetch_busy),
        .o_data_out          (data_out),
        .o_data_valid        (data_valid),
        .o_data_idx          (data_idx),
        .o_fetch_done        (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic f, input logic [7:0] a);
        ld_valid  = v;
        ld_data   = d;
        ld_last   = l;
        fetch_req = f;
        irp       = a;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic loadByte(input logic [7:0] d, input logic l, input logic isFinal);
        applyStimulus(1'b1, d, l, 1'b0, 8'h00);
        checkOutput($sformatf("load %0h ld_ready", d), ld_ready, !isFinal);
        checkOutput($sformatf("load %0h init_done", d), init_load_finished, isFinal);
    endtask

    task automatic doFetch(input string tag, input logic [7:0] addr,
                           input logic [3:0][7:0] exp);
        fetch_req = 1'b1;
        irp       = addr;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s beat%0d valid", tag, k), data_valid, 1'b1);
            checkOutput($sformatf("%s beat%0d idx", tag, k), 32'(data_idx), k);
            checkOutput($sformatf("%s beat%0d data", tag, k), data_out, exp[k]);
            checkOutput($sformatf("%s beat%0d done", tag, k), fetch_done, (k == 3));
            checkOutput($sformatf("%s beat%0d busy", tag, k), fetch_busy, (k != 3));
            @(negedge clk);
        end
        checkOutput($sformatf("%s after valid", tag), data_valid, 1'b0);
        checkOutput($sformatf("%s after done", tag), fetch_done, 1'b0);
        checkOutput($sformatf("%s after busy", tag), fetch_busy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecA[0] = '{irp: 8'h00, beats: {8'h03, 8'h02, 8'h01, 8'h80}};
        vecA[1] = '{irp: 8'h02, beats: {8'h00, 8'h00, 8'h03, 8'h02}};
        vecA[2] = '{irp: 8'h01, beats: {8'h00, 8'h03, 8'h02, 8'h01}};
        vecA[3] = '{irp: 8'hFF, beats: {8'h02, 8'h01, 8'h80, 8'h00}};
        vecA[4] = '{irp: 8'h04, beats: {8'h00, 8'h00, 8'h00, 8'h00}};

        vecB[0] = '{irp: 8'hFE, beats: {8'h5B, 8'h5A, 8'hA5, 8'hA4}};
        vecB[1] = '{irp: 8'h10, beats: {8'h49, 8'h48, 8'h4B, 8'h4A}};
        vecB[2] = '{irp: 8'h80, beats: {8'hD9, 8'hD8, 8'hDB, 8'hDA}};

        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;
        fetch_req = 1'b0;
        irp       = 8'h00;
        @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkOutput("reset ld_ready", ld_ready, 1'b1);
        checkOutput("reset init_done", init_load_finished, 1'b0);
        checkOutput("reset busy", fetch_busy, 1'b1);
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset valid", data_valid, 1'b0);
        checkOutput("reset idx", 32'(data_idx), 0);
        checkOutput("reset done", fetch_done, 1'b0);

        $display("[TB] fetch during load is ignored");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
            checkOutput("load-fetch valid", data_valid, 1'b0);
            checkOutput("load-fetch ld_ready", ld_ready, 1'b1);
            checkOutput("load-fetch init_done", init_load_finished, 1'b0);
        end

        $display("[TB] 4-byte load");
        loadByte(8'h80, 1'b0, 1'b0);
        loadByte(8'h01, 1'b0, 1'b0);
        loadByte(8'h02, 1'b0, 1'b0);
        loadByte(8'h03, 1'b1, 1'b1);

        $display("[TB] loader ignored in READY");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);
            checkOutput("ready-load ld_ready", ld_ready, 1'b0);
            checkOutput("ready-load valid", data_valid, 1'b0);
            checkOutput("ready-load init_done", init_load_finished, 1'b1);
        end

        // ld_valid stays high across these fetches: only the fetch is honoured
        for (int v = 0; v < 5; v++) begin
            doFetch($sformatf("A%0d", v), vecA[v].irp, vecA[v].beats);
        end
        ld_valid = 1'b0;

        $display("[TB] 256-byte load");
        doReset();
        for (int i = 0; i < 256; i++) begin
            loadByte(8'(i) ^ 8'h5A, 1'b0, (i == 255));
        end
        ld_valid = 1'b0;
        for (int v = 0; v < 3; v++) begin
            doFetch($sformatf("B%0d", v), vecB[v].irp, vecB[v].beats);
        end

        $display("[TB] back-to-back bursts");
        fetch_req = 1'b1;
        irp       = 8'h10;
        @(negedge clk);
        irp = 8'h20;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] base;
            base = (k < 4) ? 8'h10 : 8'h20;
            if (k == 4) fetch_req = 1'b0;
            checkOutput($sformatf("b2b beat%0d valid", k), data_valid, 1'b1);
            checkOutput($sformatf("b2b beat%0d idx", k), 32'(data_idx), k % 4);
            checkOutput($sformatf("b2b beat%0d data", k), data_out,
                        (base + 8'(k % 4)) ^ 8'h5A);
            @(negedge clk);
        end
        checkOutput("b2b end valid", data_valid, 1'b0);

        $display("[TB] request during beat 1 is not queued");
        fetch_req = 1'b1;
        irp       = 8'h30;
        @(negedge clk);
        fetch_req = 1'b0;
        checkOutput("pulse beat0 data", data_out, 8'h6A);
        @(negedge clk);
        checkOutput("pulse beat1 busy", fetch_busy, 1'b1);
        fetch_req = 1'b1;
        irp       = 8'h50;
        @(negedge clk);
        fetch_req = 1'b0;
        checkOutput("pulse beat2 data", data_out, 8'h68);
        @(negedge clk);
        checkOutput("pulse beat3 data", data_out, 8'h69);
        checkOutput("pulse beat3 done", fetch_done, 1'b1);
        @(negedge clk);
        checkOutput("pulse after valid", data_valid, 1'b0);
        @(negedge clk);
        checkOutput("pulse idle valid", data_valid, 1'b0);

        $display("[TB] reset during beat 2");
        fetch_req = 1'b1;
        irp       = 8'h00;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort beat2 idx", 32'(data_idx), 2);
        checkOutput("abort beat2 data", data_out, 8'h58);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort valid", data_valid, 1'b0);
        checkOutput("abort init_done", init_load_finished, 1'b0);
        checkOutput("abort ld_ready", ld_ready, 1'b1);
        checkOutput("abort busy", fetch_busy, 1'b1);
        checkOutput("abort done", fetch_done, 1'b0);
        @(negedge clk);
        checkOutput("abort hold valid", data_valid, 1'b0);
        loadByte(8'h0F, 1'b1, 1'b1);
        ld_valid = 1'b0;
        doFetch("C0", 8'h00, {8'h00, 8'h00, 8'h00, 8'h0F});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_store_server.md
Name: ir_store_server

Overview:
- Instruction store at the far end of the decoder's fetch interface.
- During init it accepts a byte stream from the program loader and writes it sequentially into a 256-entry store, then raises init_load_finished.
- Afterwards it answers each fetch request by streaming four consecutive bytes (IR, P0, P1, P2) starting at irp. These bytes drive the decoder's data input.

Parameters:
DATA_WIDTH, 8, width of each stored word and of the data bus
IR_ADDR_WIDTH, 8, address width; store depth is 2**IR_ADDR_WIDTH
LOAD_LINES, 256, maximum number of words accepted in the load phase (1..2**IR_ADDR_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ld_valid  in  1  loader byte valid
ld_data  in  DATA_WIDTH  loader byte
ld_last  in  1  marks final loader byte (qualified by ld_valid)
ld_ready  out  1  store accepts a loader byte this cycle
init_load_finished  out  1  load phase complete (sticky until reset)
fetch_req  in  1  decoder requests a 4-byte fetch
irp  in  IR_ADDR_WIDTH  fetch start address (sampled on accept)
fetch_busy  out  1  a new fetch_req is not accepted this cycle
data_out  out  DATA_WIDTH  fetched byte
data_valid  out  1  data_out valid
data_idx  out  2  beat index: 0=IR, 1=P0, 2=P1, 3=P2
fetch_done  out  1  one-cycle pulse on beat 3

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to LOAD; write pointer = 0; all per-word valid bits cleared.
  - Outputs: ld_ready=1 on the first cycle after reset; init_load_finished=0; fetch_busy=1; data_out=0; data_valid=0; data_idx=0; fetch_done=0.
  - Reset mid-load or mid-burst aborts the operation immediately; no partial beats follow.
- States: LOAD, READY, BURST. BURST carries a 2-bit beat counter.
- LOAD:
  - ld_ready=1.
  - A byte is accepted when ld_valid&ld_ready: it is written to mem[wptr], its valid bit is set, and wptr increments.
  - Leave LOAD for READY on the cycle after accepting a byte with ld_last=1, or after accepting the LOAD_LINES-th byte, whichever comes first.
  - init_load_finished rises in the same cycle READY is entered.
  - fetch_req is ignored in LOAD.
- READY:
  - ld_ready=0; loader inputs are ignored.
  - fetch_busy=0.
  - fetch_req=1 accepts a fetch: latch base=irp, go to BURST with beat=0.
- BURST:
  - Beat k (k=0..3) appears k+1 cycles after the accept cycle T, i.e. registered output at T+1..T+4.
  - Each beat drives data_valid=1, data_idx=k, and data_out=mem[(base+k) mod 2**IR_ADDR_WIDTH]. Address wrap: 0xFE start yields addresses FE, FF, 00, 01.
  - A word whose valid bit is clear reads as 0 (the IDLE opcode).
  - fetch_busy=1 during beats 0..2 and 0 during beat 3.
  - fetch_req asserted during beat 3 is accepted, with beat 0 of the new fetch in the next cycle (gapless back-to-back).
  - Otherwise, return to READY after beat 3, with data_valid=0 the following cycle.
  - fetch_req during beats 0..2 is ignored, not queued.
- fetch_done=1 only on beat 3.
- Store contents are writable only in LOAD; they are read-only in READY/BURST.
- data_out holds its last value when data_valid=0; consumers must qualify it with data_valid.
- Simultaneous ld_valid and fetch_req:
  - In LOAD, only the load is honoured.
  - In READY/BURST, only the fetch is honoured.

Test Plan:
- Load 4 bytes 0x80,0x01,0x02,0x03, with ld_last on the 4th -> ld_ready drops and init_load_finished=1 one cycle after the 4th accept; fetch irp=0 -> beats 0x80,0x01,0x02,0x03 at T+1..T+4, idx 0..3, fetch_done on T+4.
- Same load, then fetch irp=2 -> beats 0x02,0x03,0x00,0x00 (unwritten words read 0).
- Load 256 bytes (value = address XOR 0x5A) without ld_last -> init_load_finished after the 256th byte; fetch irp=0xFE -> beats 0xA4,0xA5,0x5A,0x5B.
- Back-to-back fetches: fetch_req held high with irp=0x10 then irp=0x20 -> 8 consecutive valid beats, no gap; a req pulsed during beat 1 is ignored.
- fetch_req during LOAD and ld_valid during READY -> no beats produced, no store modification (a later fetch returns the original data).
- rst_n asserted during beat 2 of a burst -> next cycle data_valid=0, init_load_finished=0, ld_ready=1; a later fetch after a reload of 1 byte 0x0F returns 0x0F,0,0,0.
